// File: rtl/data_path.sv
// Datapath of the K&S multicycle processor: PC, IR, 4x16 register file, ALU and flags.
// Executes control-unit enables/selects and returns instruction decode and ALU status.
package data_path_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_BRANCH = 4'd1,
        I_LOAD   = 4'd2,
        I_STORE  = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_HALT   = 4'd8
    } decoded_instruction_type;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

module data_path
    import data_path_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 4;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NREGS];
    flags_t            flags;

    logic [7:0]        opcode;
    logic [1:0]        mem_reg;
    logic [ADDR_W-1:0] ir_addr;
    logic [1:0]        c_idx;
    logic [1:0]        a_idx;
    logic [1:0]        b_idx;
    logic              unused_bits;

    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W:0]   add_full;
    flags_t            alu_flags;

    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign opcode      = ir[15:8];
    assign mem_reg     = ir[6:5];
    assign ir_addr     = ir[4:0];
    assign c_idx       = ir[5:4];
    assign a_idx       = ir[3:2];
    assign b_idx       = ir[1:0];
    assign unused_bits = ir[7];

    // Instruction decode for the control unit
    always_comb begin
        decoded_instruction = I_NOP;
        case (opcode)
            8'h01:   decoded_instruction = I_BRANCH;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    assign ram_addr = addr_sel ? ir_addr : pc;
    assign data_out = regs[mem_reg];

    assign a_val    = regs[a_idx];
    assign b_val    = regs[b_idx];
    assign add_full = {1'b0, a_val} + {1'b0, b_val};

    // ALU result and the status it would load into the flags register
    always_comb begin
        alu_result      = '0;
        alu_flags.carry = 1'b0;
        alu_flags.ovf   = 1'b0;
        case (operation)
            2'b00: begin
                alu_result      = add_full[DATA_W-1:0];
                alu_flags.carry = add_full[DATA_W];
                alu_flags.ovf   = (a_val[DATA_W-1] == b_val[DATA_W-1]) &&
                                  (alu_result[DATA_W-1] != a_val[DATA_W-1]);
            end
            2'b01: begin
                alu_result      = a_val - b_val;
                alu_flags.carry = (a_val < b_val);
                alu_flags.ovf   = (a_val[DATA_W-1] != b_val[DATA_W-1]) &&
                                  (alu_result[DATA_W-1] != a_val[DATA_W-1]);
            end
            2'b10:   alu_result = a_val & b_val;
            default: alu_result = a_val | b_val;
        endcase
        alu_flags.zero = (alu_result == '0);
        alu_flags.neg  = alu_result[DATA_W-1];
    end

    assign wr_idx  = c_sel ? mem_reg : c_idx;
    assign wr_data = c_sel ? data_in : alu_result;

    // Architectural state; reset wins over every enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else begin
            if (ir_enable) ir <= data_in;
            if (pc_enable) pc <= branch ? ir_addr : pc + ADDR_W'(1);
            if (write_reg_enable) regs[wr_idx] <= wr_data;
            if (flags_reg_enable) flags <= alu_flags;
        end
    end

    assign zero_op           = flags.zero;
    assign neg_op            = flags.neg;
    assign unsigned_overflow = flags.carry;
    assign signed_overflow   = flags.ovf;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: expectations queued on stimulus, popped and checked at observation.
module tb_data_path;
    import data_path_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out;
    logic [15:0]             data_in;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int total = 0;
    int bad   = 0;

    data_path dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        sb_entry_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [15:0] flag_vec();
        return {12'h000, zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic load_ir(input logic [15:0] w);
        data_in   = w;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [15:0] val);
        load_ir({8'h81, 1'b0, idx, 5'h00});
        data_in          = val;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] idx, input logic [15:0] exp, input string tag);
        load_ir({8'h82, 1'b0, idx, 5'h00});
        push(tag, exp);
        check(data_out);
    endtask

    task automatic alu_step(input logic [15:0] instr, input logic [1:0] op,
                            input logic wre, input logic fre);
        load_ir(instr);
        operation        = op;
        c_sel            = 1'b0;
        write_reg_enable = wre;
        flags_reg_enable = fre;
        tick();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
    endtask

    // Full-featured ALU case: set R1/R2, run op writing R[c], check result and flags
    task automatic alu_case(input string tag, input logic [15:0] instr, input logic [1:0] op,
                            input logic [15:0] r1, input logic [15:0] r2,
                            input logic [15:0] exp_res, input logic [3:0] exp_flags);
        logic [1:0] dst;
        dst = instr[5:4];
        write_reg(2'd1, r1);
        write_reg(2'd2, r2);
        alu_step(instr, op, 1'b1, 1'b1);
        push({tag, "_flags"}, {12'h000, exp_flags});
        check(flag_vec());
        read_reg(dst, exp_res, {tag, "_result"});
    endtask

    initial begin
        logic [7:0]  opcodes [10];
        logic [3:0]  decs    [10];
        logic [15:0] flags_before;

        rst = 1'b1; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
        write_reg_enable = 1'b0; addr_sel = 1'b0; c_sel = 1'b0;
        operation = 2'b00; flags_reg_enable = 1'b0; data_in = 16'h0000;
        tick();
        tick();
        rst = 1'b0;

        // Junk state everywhere, then reset with every enable high
        write_reg(2'd0, 16'hDEAD);
        write_reg(2'd1, 16'h8001);
        write_reg(2'd2, 16'h8001);
        write_reg(2'd3, 16'h1234);
        alu_step(16'hA126, 2'b00, 1'b0, 1'b1);
        load_ir(16'h0117);
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        branch = 1'b0; pc_enable = 1'b0;

        rst = 1'b1; ir_enable = 1'b1; pc_enable = 1'b1; write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1; c_sel = 1'b1; data_in = 16'hA1FF;
        tick();
        rst = 1'b0; ir_enable = 1'b0; pc_enable = 1'b0; write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0; c_sel = 1'b0;

        addr_sel = 1'b0;
        push("rst_pc", 16'd0);          check(16'(ram_addr));
        addr_sel = 1'b1; #1;
        push("rst_ir_addr", 16'd0);     check(16'(ram_addr));
        addr_sel = 1'b0;
        push("rst_decode", 16'(I_NOP)); check(16'(decoded_instruction));
        push("rst_flags", 16'h0000);    check(flag_vec());
        push("rst_data_out", 16'h0000); check(data_out);
        read_reg(2'd1, 16'h0000, "rst_r1");
        read_reg(2'd2, 16'h0000, "rst_r2");
        read_reg(2'd3, 16'h0000, "rst_r3");

        // Reset again so PC starts from 0 for the fetch sequence
        rst = 1'b1; tick(); rst = 1'b0;

        // Fetch cycle: IR takes data_in while PC increments
        data_in = 16'h815F; ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b0;
        tick();
        ir_enable = 1'b0; pc_enable = 1'b0;
        push("fetch_decode", 16'(I_LOAD)); check(16'(decoded_instruction));
        push("fetch_pc", 16'd1);           check(16'(ram_addr));
        addr_sel = 1'b1; #1;
        push("load_addr", 16'd31);         check(16'(ram_addr));
        addr_sel = 1'b0;
        data_in = 16'hBEEF; c_sel = 1'b1; write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        load_ir(16'h825F);
        push("store_decode", 16'(I_STORE)); check(16'(decoded_instruction));
        push("store_data", 16'hBEEF);       check(data_out);
        push("store_pc_hold", 16'd1);       check(16'(ram_addr));

        // Same-cycle write leaves the old value visible until the edge
        data_in = 16'h1111; c_sel = 1'b1; write_reg_enable = 1'b1; #1;
        push("rd_during_wr", 16'hBEEF); check(data_out);
        tick();
        write_reg_enable = 1'b0;
        push("rd_after_wr", 16'h1111);  check(data_out);

        // ALU: {zero,neg,carry,ovf}
        alu_case("add_sovf",  16'hA136, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        alu_case("add_carry", 16'hA136, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        alu_case("sub_zero",  16'hA206, 2'b01, 16'h0005, 16'h0005, 16'h0000, 4'b1000);
        alu_case("sub_borrow",16'hA206, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110);

        // Register write without flags load leaves flags untouched
        flags_before = flag_vec();
        write_reg(2'd1, 16'h0005);
        write_reg(2'd2, 16'h0005);
        alu_step(16'hA206, 2'b01, 1'b1, 1'b0);
        push("flags_hold", 16'h0006);   check(flag_vec());
        read_reg(2'd0, 16'h0000, "sub_nowr_flags_result");
        push("flags_hold_snapshot", flags_before); check(flag_vec());

        alu_case("sub_sovf",  16'hA216, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
        alu_case("and",       16'hA326, 2'b10, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
        alu_case("or",        16'hA436, 2'b11, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0100);

        // Flags-only update: register must keep its value
        write_reg(2'd3, 16'h4242);
        write_reg(2'd1, 16'h0000);
        write_reg(2'd2, 16'h0000);
        alu_step(16'hA136, 2'b00, 1'b0, 1'b1);
        push("flags_only", 16'h0008);   check(flag_vec());
        read_reg(2'd3, 16'h4242, "flags_only_r3");

        // Branch, then wrap from 31
        load_ir(16'h0114);
        push("br_decode", 16'(I_BRANCH)); check(16'(decoded_instruction));
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        branch = 1'b0; pc_enable = 1'b0;
        push("br_pc", 16'd20);          check(16'(ram_addr));
        load_ir(16'h011F);
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        branch = 1'b0;
        push("pc_31", 16'd31);          check(16'(ram_addr));
        tick();
        pc_enable = 1'b0;
        push("pc_wrap", 16'd0);         check(16'(ram_addr));

        // Hold with all enables low
        repeat (5) tick();
        push("hold_pc", 16'd0);         check(16'(ram_addr));
        push("hold_flags", 16'h0008);   check(flag_vec());

        // Decode table including unknown opcodes
        opcodes = '{8'h00, 8'h01, 8'h81, 8'h82, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h55};
        decs    = '{4'(I_NOP), 4'(I_BRANCH), 4'(I_LOAD), 4'(I_STORE), 4'(I_ADD),
                    4'(I_SUB), 4'(I_AND), 4'(I_OR), 4'(I_HALT), 4'(I_NOP)};
        for (int i = 0; i < 10; i++) begin
            load_ir({opcodes[i], 8'h00});
            push($sformatf("decode_%02h", opcodes[i]), 16'(decs[i]));
            check(16'(decoded_instruction));
        end
        load_ir(16'hA500);
        push("decode_a5", 16'(I_NOP));  check(16'(decoded_instruction));

        if (sb.size() != 0) begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Datapath for the K&S multicycle processor. It holds the program counter, instruction register, 4×16-bit register file, ALU and flags register. It decodes the current instruction for the control unit and returns ALU status flags to it. It is the counterpart of the control unit across the control/status interface: it executes the enables and selects the control unit issues and drives the RAM address, write data and read data path.

## Interface
Parameters:
- none; fixed widths: data 16 bits, RAM address 5 bits, 4 registers.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- branch  in  1  PC load source select: 1 = IR address field, 0 = PC+1
- pc_enable  in  1  PC update enable
- ir_enable  in  1  IR load from data_in
- write_reg_enable  in  1  register file write enable
- addr_sel  in  1  ram_addr select: 1 = IR address field, 0 = PC
- c_sel  in  1  write-back select: 1 = data_in to ir[6:5], 0 = ALU result to ir[5:4]
- operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- flags_reg_enable  in  1  flags register load enable
- decoded_instruction  out  decoded_instruction_type  decode of IR
- zero_op  out  1  registered zero flag
- neg_op  out  1  registered negative flag
- unsigned_overflow  out  1  registered carry/borrow flag
- signed_overflow  out  1  registered signed overflow flag
- ram_addr  out  5  RAM address
- data_out  out  16  RAM write data
- data_in  in  16  RAM read data

## Operation
- Instruction fields:
  - opcode = ir[15:8]
  - memory/branch: reg = ir[6:5], addr = ir[4:0]
  - ALU: c = ir[5:4], a = ir[3:2], b = ir[1:0]
- Decode, combinational from IR:
  - 0x00 → I_NOP
  - 0x01 → I_BRANCH
  - 0x81 → I_LOAD
  - 0x82 → I_STORE
  - 0xA1 → I_ADD
  - 0xA2 → I_SUB
  - 0xA3 → I_AND
  - 0xA4 → I_OR
  - 0xFF → I_HALT
  - any other opcode → I_NOP
- IR: loads data_in when ir_enable.
- PC update when pc_enable:
  - branch=1: PC ← ir[4:0]
  - branch=0: PC ← PC+1, modulo 32, so 31 wraps to 0.
- ram_addr = addr_sel ? ir[4:0] : PC, combinational.
- data_out = R[ir[6:5]], combinational.
- ALU, 16-bit: A = R[a], B = R[b], result per operation.
- Register write when write_reg_enable:
  - c_sel=1: R[ir[6:5]] ← data_in
  - c_sel=0: R[ir[5:4]] ← ALU result
  - R0 is an ordinary register.
- Flags, computed from the current ALU result and loaded when flags_reg_enable:
  - zero = (result == 0)
  - neg = result[15]
  - unsigned_overflow: carry out of bit 15 for ADD; borrow (A < B unsigned) for SUB; 0 for AND/OR.
  - signed_overflow: for ADD, operands of equal sign and result sign different; for SUB, operand signs differ and result sign ≠ A sign; 0 for AND/OR.
- Flags and register writes are independent: either may occur without the other.

## Timing
- Reset, synchronous: PC=0, IR=0x0000 (decoded I_NOP), all registers 0, all four flags 0.
  - Resulting outputs: ram_addr=0 (when addr_sel=0), data_out=0.
  - rst overrides every enable in the same cycle.
- IR, PC, registers and flags update at the rising edge where their enable is high; new value visible the cycle after.
- decoded_instruction, ram_addr and data_out are combinational from the current state. Zero latency after the IR/PC edge.
- Register read during a write in the same cycle returns the old value.
- ir_enable and pc_enable together (fetch cycle): IR takes data_in while PC increments from its pre-edge value. Fetched word comes from RAM[old PC].
- pc_enable with branch: target is the pre-edge ir[4:0].
- Enables deasserted: all state holds indefinitely. Required during HALT.
- Flag outputs change only on a flags_reg_enable edge or reset, never combinationally.

## Test plan
- Reset: drive junk state, assert rst one cycle → PC=0, IR=0, decoded I_NOP, all flags 0, all registers 0, data_out=0.
- Fetch + LOAD, then STORE:
  - Steps: data_in=0x815F with ir_enable=pc_enable=1 → IR=0x815F, PC 0→1, I_LOAD. addr_sel=1 → ram_addr=31. data_in=0xBEEF with c_sel=1, write_reg_enable=1 → R2=0xBEEF.
  - Then load IR=0x825F → I_STORE, data_out=0xBEEF.
- ADD overflow: R1=0x7FFF, R2=0x0001, IR=0xA136, operation=00, write_reg_enable=flags_reg_enable=1 → R3=0x8000, neg=1, zero=0, signed_overflow=1, unsigned_overflow=0.
- SUB:
  - R1=R2=5, IR=0xA206 (c=0, a=1, b=2) → R0=0, zero=1.
  - R1=0, R2=1 → R0=0xFFFF, neg=1, unsigned_overflow=1, signed_overflow=0.
  - Flags unchanged when flags_reg_enable=0.
- Branch and wrap:
  - IR=0x0114, branch=pc_enable=1 → PC=20, I_BRANCH.
  - PC=31, pc_enable=1, branch=0 → PC=0.
  - Unknown opcode 0x55 → I_NOP.
- Reset mid-operation: rst=1 together with write_reg_enable, flags_reg_enable, pc_enable, ir_enable → all state reset values, no write takes effect.
